// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Used by uart_rx_sync and uart_rx_deframer.
package uart_pkg;

    // Receive FSM states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    // Level of an idle (marking) serial line
    localparam logic UART_IDLE_LEVEL = 1'b1;

    // 2-of-3 majority vote
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Synchroniser for the asynchronous rx pad input.
// SYNC_STAGES-deep flop chain, reset to the idle line level.
// With UART_RX_MAJORITY_EN defined, the stage in front of the last one is
// also exported so the deframer can see the "next" synchronised sample.
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rx_i,
    output logic rxs_o
`ifdef UART_RX_MAJORITY_EN
    ,
    output logic rx_ahead_o
`endif
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], rx_i};

    // Shift the raw line through the chain; reset looks like an idle line
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {SYNC_STAGES{UART_IDLE_LEVEL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rxs_o = sync_q[SYNC_STAGES-1];
`ifdef UART_RX_MAJORITY_EN
    assign rx_ahead_o = sync_q[SYNC_STAGES-2];
`endif

endmodule

// File: rtl/uart_rx_deframer.sv
// UART 8N1 receive deframer: synchronises rx_i, finds start bits, samples
// each bit at its middle, and hands bytes out over valid/ready.
// Optional build macro: UART_RX_MAJORITY_EN -- every bit decision is a 2-of-3
// vote of the synchronised line at mid-1, mid, mid+1 (mid+1 is taken from the
// synchroniser stage ahead of the last one, so decision timing is unchanged).
//
// Handshake: data_o is valid and stable while valid_o=1; a byte is transferred
// in any cycle where valid_o & ready_i. valid_o stays high until transferred.
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int BAUD_DIV    = 868,
    parameter int D_WIDTH     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               rx_i,
    output logic [D_WIDTH-1:0] data_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               frame_err_o,
    output logic               overrun_o
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam int IDX_W = $clog2(D_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BAUD_DIV / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(D_WIDTH - 1);

    logic rxs;
    logic sample_bit;

    rx_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [D_WIDTH-1:0] shreg_q, shreg_d;

    logic byte_done;
    logic ferr_set;

    logic [D_WIDTH-1:0] data_q, data_d;
    logic               valid_q, valid_d;
    logic               ferr_q, ferr_d;
    logic               ovr_q, ovr_d;

`ifdef UART_RX_MAJORITY_EN
    logic rx_ahead;
    logic rxs_prev_q;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rx_i       (rx_i),
        .rxs_o      (rxs),
        .rx_ahead_o (rx_ahead)
    );

    // Remember the previous synchronised sample for the vote
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rxs_prev_q <= UART_IDLE_LEVEL;
        end else begin
            rxs_prev_q <= rxs;
        end
    end

    assign sample_bit = maj3(rxs_prev_q, rxs, rx_ahead);
`else
    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .rx_i  (rx_i),
        .rxs_o (rxs)
    );

    assign sample_bit = rxs;
`endif

    // Receive FSM and bit timing registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

    // Next-state logic: start detect, mid-bit sampling, stop check
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        byte_done = 1'b0;
        ferr_set  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rxs != UART_IDLE_LEVEL) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d = '0;
                    if (sample_bit != UART_IDLE_LEVEL) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end else begin
                        // start bit vanished before its middle: treat as noise
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    // LSB arrives first, so shift in from the top
                    shreg_d = D_WIDTH'({sample_bit, shreg_q} >> 1);
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (sample_bit == UART_IDLE_LEVEL) begin
                        byte_done = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BREAK: begin
                // a line held low reports one error; wait for it to recover
                cnt_d = '0;
                if (rxs == UART_IDLE_LEVEL) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output holding register and error pulse flops
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    // Load on completion when the slot is free or being drained this cycle
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = ferr_set;
        ovr_d   = 1'b0;
        if (byte_done) begin
            if (!valid_q || ready_i) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                // slot full and not draining: keep old byte, drop new one
                ovr_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer at 16 clk/bit, 8 data bits.
// Honours UART_RX_MAJORITY_EN for the spike scenario.
module tb_uart_rx_deframer;
    import uart_pkg::*;

    localparam int BAUD_DIV    = 16;
    localparam int D_WIDTH     = 8;
    localparam int SYNC_STAGES = 2;
    // Within a bit cell the receiver decides at offset BAUD_DIV/2 + 1
    // (one cycle to notice the start edge after the synchroniser).
    localparam int SAMPLE_OFS  = BAUD_DIV / 2 + 1;
    // valid_o rises one cycle after the stop-bit decision, which itself is
    // SYNC_STAGES cycles behind the pad.
    localparam int EXP_VALID_OFS = 9 * BAUD_DIV + SAMPLE_OFS + SYNC_STAGES + 1;

    logic               clk;
    logic               rst_i;
    logic               rx_i;
    logic               ready_i;
    logic [D_WIDTH-1:0] data_o;
    logic               valid_o;
    logic               frame_err_o;
    logic               overrun_o;

    int tests_run;
    int tests_failed;

    int cyc;
    int first_valid;
    int valid_hi;
    int err_cnt;
    int ovr_cnt;
    int both_cnt;
    logic [D_WIDTH-1:0] got_q[$];
    logic [D_WIDTH-1:0] exp_q[$];

    uart_rx_deframer #(
        .BAUD_DIV    (BAUD_DIV),
        .D_WIDTH     (D_WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor (negedge, away from active edge) ----------------
    initial begin
        first_valid = -1;
        valid_hi    = 0;
        err_cnt     = 0;
        ovr_cnt     = 0;
        both_cnt    = 0;
    end

    always @(negedge clk) begin
        if (!rst_i) begin
            if (valid_o) begin
                valid_hi = valid_hi + 1;
                if (first_valid < 0) first_valid = cyc;
            end
            if (valid_o && ready_i) got_q.push_back(data_o);
            if (frame_err_o) err_cnt = err_cnt + 1;
            if (overrun_o) ovr_cnt = ovr_cnt + 1;
            if (frame_err_o && overrun_o) both_cnt = both_cnt + 1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_mon();
        got_q.delete();
        exp_q.delete();
        first_valid = -1;
        valid_hi    = 0;
        err_cnt     = 0;
        ovr_cnt     = 0;
    endtask

    // Hold the line at lvl for n cycles; returns at posedge+1
    task automatic hold(input logic lvl, input int n);
        rx_i = lvl;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_lvl);
        hold(1'b0, BAUD_DIV);
        for (int i = 0; i < D_WIDTH; i++) hold(b[i], BAUD_DIV);
        hold(stop_lvl, BAUD_DIV);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_i   = 1'b1;
        rx_i    = 1'b1;
        ready_i = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        tests_run++;
        if ({valid_o, frame_err_o, overrun_o} !== 3'b000 || data_o !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_outputs: got valid=%b ferr=%b ovr=%b data=%h expected all 0",
                     valid_o, frame_err_o, overrun_o, data_o);
        end
        tests_run++;
        if (dut.state_q !== IDLE) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE);
        end
        rst_i = 1'b0;
        hold(1'b1, 10);
    endtask

    task automatic test_basic_a5();
        int c0;
        clear_mon();
        ready_i = 1'b1;
        hold(1'b1, 20);
        c0 = cyc;
        send_frame(8'hA5, 1'b1);
        hold(1'b1, 20);
        tests_run++;
        if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin
            tests_failed++;
            $display("FAIL basic_data: got %0d bytes first=%h expected 1 byte a5",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
        end
        tests_run++;
        if (first_valid != c0 + EXP_VALID_OFS) begin
            tests_failed++;
            $display("FAIL basic_latency: valid at cycle offset %0d expected %0d",
                     first_valid - c0, EXP_VALID_OFS);
        end
        tests_run++;
        if (valid_hi != 1) begin
            tests_failed++;
            $display("FAIL basic_valid_width: got %0d cycles expected 1", valid_hi);
        end
        tests_run++;
        if (err_cnt != 0 || ovr_cnt != 0) begin
            tests_failed++;
            $display("FAIL basic_no_errors: got ferr=%0d ovr=%0d expected 0 0", err_cnt, ovr_cnt);
        end
    endtask

    task automatic test_glitch();
        clear_mon();
        hold(1'b0, 5);
        hold(1'b1, 30);
        tests_run++;
        if (dut.state_q !== IDLE) begin
            tests_failed++;
            $display("FAIL glitch_state: got %0d expected %0d", dut.state_q, IDLE);
        end
        tests_run++;
        if (valid_hi != 0 || err_cnt != 0) begin
            tests_failed++;
            $display("FAIL glitch_quiet: got valid_cycles=%0d ferr=%0d expected 0 0",
                     valid_hi, err_cnt);
        end
    endtask

    task automatic test_frame_error();
        logic [7:0] b;
        clear_mon();
        b = 8'h3C;
        hold(1'b0, BAUD_DIV);
        for (int i = 0; i < D_WIDTH; i++) hold(b[i], BAUD_DIV);
        hold(1'b0, 100);
        hold(1'b1, 20);
        tests_run++;
        if (err_cnt != 1) begin
            tests_failed++;
            $display("FAIL ferr_count: got %0d pulses expected 1", err_cnt);
        end
        tests_run++;
        if (valid_hi != 0) begin
            tests_failed++;
            $display("FAIL ferr_no_valid: got %0d valid cycles expected 0", valid_hi);
        end
        clear_mon();
        send_frame(8'h01, 1'b1);
        hold(1'b1, 20);
        tests_run++;
        if (got_q.size() != 1 || got_q[0] !== 8'h01 || err_cnt != 0) begin
            tests_failed++;
            $display("FAIL ferr_recover: got %0d bytes first=%h ferr=%0d expected 1 byte 01 ferr 0",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, err_cnt);
        end
    endtask

    task automatic test_overrun();
        clear_mon();
        ready_i = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        hold(1'b1, 20);
        tests_run++;
        if (data_o !== 8'h11 || valid_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovr_hold: got data=%h valid=%b expected 11 1", data_o, valid_o);
        end
        tests_run++;
        if (ovr_cnt != 1 || got_q.size() != 0) begin
            tests_failed++;
            $display("FAIL ovr_pulse: got ovr=%0d accepted=%0d expected 1 0", ovr_cnt, got_q.size());
        end
        ready_i = 1'b1;
        hold(1'b1, 3);
        tests_run++;
        if (got_q.size() != 1 || got_q[0] !== 8'h11 || valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovr_drain: got %0d bytes first=%h valid=%b expected 1 byte 11 valid 0",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, valid_o);
        end
    endtask

    task automatic test_same_cycle();
        clear_mon();
        ready_i = 1'b0;
        send_frame(8'h11, 1'b1);
        fork
            send_frame(8'h22, 1'b1);
            begin
                // raise ready_i exactly in the stop-decision cycle of 0x22
                repeat (EXP_VALID_OFS - 1) @(posedge clk);
                #1;
                ready_i = 1'b1;
                @(posedge clk);
                #1;
                tests_run++;
                if (data_o !== 8'h22 || valid_o !== 1'b1 || overrun_o !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL same_cycle_load: got data=%h valid=%b ovr=%b expected 22 1 0",
                             data_o, valid_o, overrun_o);
                end
            end
        join
        hold(1'b1, 20);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        tests_run++;
        if (got_q != exp_q || ovr_cnt != 0) begin
            tests_failed++;
            $display("FAIL same_cycle_stream: got %0d bytes ovr=%0d expected 11,22 ovr 0",
                     got_q.size(), ovr_cnt);
        end
    endtask

    task automatic test_random_stream();
        logic [7:0] b;
        clear_mon();
        ready_i = 1'b1;
        for (int n = 0; n < 6; n++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, 1'b1);
            hold(1'b1, $urandom_range(0, 12));
        end
        hold(1'b1, 20);
        tests_run++;
        if (got_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL rand_count: got %0d bytes expected %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                tests_run++;
                if (got_q[i] !== exp_q[i]) begin
                    tests_failed++;
                    $display("FAIL rand_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_spike();
        logic [7:0] b;
        logic [7:0] exp_b;
        int k;
        clear_mon();
        ready_i = 1'b1;
        b    = 8'($urandom_range(0, 255));
        k    = $urandom_range(0, 7);
        b[k] = 1'b1;
        hold(1'b0, BAUD_DIV);
        for (int i = 0; i < D_WIDTH; i++) begin
            if (i == k) begin
                hold(1'b1, SAMPLE_OFS);
                hold(1'b0, 1);
                hold(1'b1, BAUD_DIV - SAMPLE_OFS - 1);
            end else begin
                hold(b[i], BAUD_DIV);
            end
        end
        hold(1'b1, BAUD_DIV);
        hold(1'b1, 20);
`ifdef UART_RX_MAJORITY_EN
        exp_b = b;
`else
        exp_b = b & ~(8'h01 << k);
`endif
        tests_run++;
        if (got_q.size() != 1 || got_q[0] !== exp_b) begin
            tests_failed++;
            $display("FAIL spike_bit%0d: got %0d bytes first=%h expected %h",
                     k, got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, exp_b);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        clear_mon();
        ready_i = 1'b1;
        b = 8'h96;
        hold(1'b0, BAUD_DIV);
        for (int i = 0; i < 4; i++) hold(b[i], BAUD_DIV);
        hold(b[4], BAUD_DIV / 2);
        rst_i = 1'b1;
        hold(1'b1, 3);
        tests_run++;
        if ({valid_o, frame_err_o, overrun_o} !== 3'b000 || data_o !== 8'h00) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got valid=%b ferr=%b ovr=%b data=%h expected all 0",
                     valid_o, frame_err_o, overrun_o, data_o);
        end
        rst_i = 1'b0;
        hold(1'b1, 20);
        tests_run++;
        if (got_q.size() != 0 || err_cnt != 0) begin
            tests_failed++;
            $display("FAIL midreset_abort: got %0d bytes ferr=%0d expected 0 0", got_q.size(), err_cnt);
        end
        send_frame(8'h5A, 1'b1);
        hold(1'b1, 20);
        tests_run++;
        if (got_q.size() != 1 || got_q[0] !== 8'h5A) begin
            tests_failed++;
            $display("FAIL midreset_next: got %0d bytes first=%h expected 1 byte 5a",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
        end
    endtask

    task automatic test_no_dual_pulse();
        tests_run++;
        if (both_cnt != 0) begin
            tests_failed++;
            $display("FAIL dual_pulse: got %0d cycles with ferr and ovr together expected 0", both_cnt);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_i   = 1'b1;
        rx_i    = 1'b1;
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_basic_a5();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_same_cycle();
        test_random_stream();
        test_spike();
        test_reset_midframe();
        test_no_dual_pulse();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
